// File: rtl/pipe_add_cmp.sv
// rtl/pipe_add_cmp.sv - pipelined add/subtract with registered unsigned compare
module pipe_add_cmp #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int SDIV  = (STAGES > 0) ? STAGES : 1;
  localparam int CHUNK = (WIDTH / SDIV > 0) ? WIDTH / SDIV : 1;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % SDIV) != 0) begin : g_bad_params
    $error("pipe_add_cmp: WIDTH must be >= 1 and an exact multiple of STAGES >= 1");
  end

  // rdy[k] is the ready seen by stage k's producer; rdy[STAGES] comes from the consumer
  logic [STAGES:0] rdy;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // RW: operand bits still to be summed entering this stage (own chunk at the LSBs)
    // SW: sum bits completed once this stage has registered its chunk
    localparam int RW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic           vin;
    logic [RW-1:0]  ain;
    logic [RW-1:0]  bin;
    logic           cin;
    logic           eqi;
    logic           gti;
    logic           lti;
    logic [CHUNK:0] csum;
    logic [SW-1:0]  snext;

    logic           v_q;
    logic [SW-1:0]  s_q;
    logic           c_q;
    logic           eq_q;
    logic           gt_q;
    logic           lt_q;

    if (k == 0) begin : g_src
      // Subtraction is a + ~b + 1; the compare uses the raw operands
      assign vin   = in_valid;
      assign ain   = a;
      assign bin   = sub ? ~b : b;
      assign cin   = sub;
      assign eqi   = (a == b);
      assign gti   = (a > b);
      assign lti   = (a < b);
      assign snext = csum[CHUNK-1:0];
    end else begin : g_src
      assign vin   = g_st[k-1].v_q;
      assign ain   = g_st[k-1].g_ops.a_q;
      assign bin   = g_st[k-1].g_ops.b_q;
      assign cin   = g_st[k-1].c_q;
      assign eqi   = g_st[k-1].eq_q;
      assign gti   = g_st[k-1].gt_q;
      assign lti   = g_st[k-1].lt_q;
      assign snext = {csum[CHUNK-1:0], g_st[k-1].s_q};
    end

    assign csum   = {1'b0, ain[CHUNK-1:0]} + {1'b0, bin[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};
    assign rdy[k] = !v_q || rdy[k+1];

    // Stage register: advance when downstream has room, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        s_q  <= '0;
        c_q  <= 1'b0;
        eq_q <= 1'b0;
        gt_q <= 1'b0;
        lt_q <= 1'b0;
      end else if (rdy[k]) begin
        v_q <= vin;
        if (vin) begin
          s_q  <= snext;
          c_q  <= csum[CHUNK];
          eq_q <= eqi;
          gt_q <= gti;
          lt_q <= lti;
        end
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [RW-CHUNK-1:0] a_q;
      logic [RW-CHUNK-1:0] b_q;

      // Unprocessed upper operand bits ride along to the next stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k] && vin) begin
          a_q <= ain[RW-1:CHUNK];
          b_q <= bin[RW-1:CHUNK];
        end
      end
    end else begin : g_msb
      logic ovf_q;

      // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (rdy[k] && vin) begin
          ovf_q <= (ain[CHUNK-1] ^ bin[CHUNK-1] ^ csum[CHUNK-1]) ^ csum[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign ovf       = g_st[STAGES-1].g_msb.ovf_q;
  assign eq        = g_st[STAGES-1].eq_q;
  assign gt        = g_st[STAGES-1].gt_q;
  assign lt        = g_st[STAGES-1].lt_q;

endmodule
